// File: rtl/bird_motion_controller_pkg.sv
// Shared game definitions: game state encoding, screen geometry and the
// default bird row width used by the bird motion controller and its
// physics step.
package bird_motion_controller_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StPlay  = 2'd1,
    StCrash = 2'd2
  } game_state_e;

  localparam int unsigned ScreenW  = 160;
  localparam int unsigned ScreenH  = 120;
  localparam int unsigned YW       = 7;
  localparam int unsigned ScoreMax = 99;

endpackage

// File: rtl/bird_physics_step.sv
// One frame of bird physics, purely combinational.
//   bird_y    : current row
//   vel       : current velocity (signed rows/frame)
//   use_flap  : a flap is to be applied this frame
//   y_new     : row after this frame, clamped to 0..Y_MAX
//   vel_new   : velocity after this frame (zeroed on ceiling clamp)
//   hit_floor : the move reached or passed the floor row
module bird_physics_step
  import bird_motion_controller_pkg::*;
#(
  parameter int unsigned Y_W      = YW,
  parameter int unsigned Y_MAX    = 112,
  parameter int          FLAP_VEL = -4,
  parameter int          VEL_MAX  = 4
) (
  input  logic [Y_W-1:0]    bird_y,
  input  logic signed [4:0] vel,
  input  logic              use_flap,
  output logic [Y_W-1:0]    y_new,
  output logic signed [4:0] vel_new,
  output logic              hit_floor
);

  localparam logic signed [4:0]     FlapVel = 5'(FLAP_VEL);
  localparam logic signed [4:0]     VelMax  = 5'(VEL_MAX);
  localparam logic signed [Y_W+1:0] YMaxExt = (Y_W + 2)'(Y_MAX);
  localparam logic signed [Y_W+1:0] YZero   = '0;

  logic signed [4:0]     vel_c;
  logic signed [Y_W+1:0] y_sum;

  always_comb begin
    vel_c     = use_flap ? FlapVel : ((vel >= VelMax) ? VelMax : vel + 5'sd1);
    // Two guard bits so both overshoot directions stay representable.
    y_sum     = $signed({2'b00, bird_y}) + $signed({{(Y_W - 3){vel_c[4]}}, vel_c});
    y_new     = y_sum[Y_W-1:0];
    vel_new   = vel_c;
    hit_floor = 1'b0;
    if (y_sum <= YZero) begin
      y_new   = '0;
      vel_new = '0;
    end else if (y_sum >= YMaxExt) begin
      y_new     = Y_W'(Y_MAX);
      hit_floor = 1'b1;
    end
  end

endmodule

// File: rtl/bird_motion_controller.sv
// Bird sequencing for one game: IDLE/PLAY/CRASH state, per-frame height
// integration, floor and pipe crash detection, score, and a req/ack
// handshake presenting each position update to the renderer.
//   clk, reset   : clock, synchronous active-high reset
//   flap_pulse   : one-cycle flap request
//   frame_tick   : one-cycle pulse per video frame
//   pipe_hit     : level, bird overlaps a pipe
//   pipe_passed  : one-cycle pulse, pipe cleared
//   draw_ack     : renderer accepted draw_req
//   bird_y/old_y : current row / row before the last update
//   draw_req     : redraw pending
//   game_state   : 0 IDLE, 1 PLAY, 2 CRASH
//   score        : pipes passed, saturating at 99
//   overrun      : sticky, a frame_tick was dropped while draw_req was high
module bird_motion_controller
  import bird_motion_controller_pkg::*;
#(
  parameter int unsigned Y_W        = YW,
  parameter int unsigned Y_START    = 60,
  parameter int unsigned Y_MAX      = 112,
  parameter int          FLAP_VEL   = -4,
  parameter int          VEL_MAX    = 4,
  parameter int unsigned CRASH_HOLD = 60
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           flap_pulse,
  input  logic           frame_tick,
  input  logic           pipe_hit,
  input  logic           pipe_passed,
  input  logic           draw_ack,
  output logic [Y_W-1:0] bird_y,
  output logic           draw_req,
  output logic [Y_W-1:0] old_y,
  output logic [1:0]     game_state,
  output logic [6:0]     score,
  output logic           overrun
);

  localparam logic signed [4:0] FlapVel   = 5'(FLAP_VEL);
  localparam logic [Y_W-1:0]    YStart    = Y_W'(Y_START);
  localparam logic [6:0]        CrashHold = 7'(CRASH_HOLD);
  localparam logic [6:0]        ScoreTop  = 7'(ScoreMax);

  game_state_e       state_q, state_d;
  logic [Y_W-1:0]    bird_y_q, bird_y_d, old_y_q, old_y_d;
  logic signed [4:0] vel_q, vel_d;
  logic [6:0]        score_q, score_d, hold_q, hold_d;
  logic              draw_req_q, draw_req_d, overrun_q, overrun_d;
  logic              flap_pending_q, flap_pending_d;
  // Set on launch so the launching flap's velocity drives the first frame.
  logic              launch_q, launch_d;

  logic              update;
  logic [Y_W-1:0]    y_new;
  logic signed [4:0] vel_new;
  logic              hit_floor;

  assign update = (state_q == StPlay) && frame_tick && !draw_req_q;

  bird_physics_step #(
    .Y_W      (Y_W),
    .Y_MAX    (Y_MAX),
    .FLAP_VEL (FLAP_VEL),
    .VEL_MAX  (VEL_MAX)
  ) u_physics (
    .bird_y    (bird_y_q),
    .vel       (vel_q),
    .use_flap  (flap_pending_q | launch_q),
    .y_new     (y_new),
    .vel_new   (vel_new),
    .hit_floor (hit_floor)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= StIdle;
      bird_y_q       <= YStart;
      old_y_q        <= YStart;
      vel_q          <= '0;
      score_q        <= '0;
      hold_q         <= '0;
      draw_req_q     <= 1'b0;
      overrun_q      <= 1'b0;
      flap_pending_q <= 1'b0;
      launch_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      bird_y_q       <= bird_y_d;
      old_y_q        <= old_y_d;
      vel_q          <= vel_d;
      score_q        <= score_d;
      hold_q         <= hold_d;
      draw_req_q     <= draw_req_d;
      overrun_q      <= overrun_d;
      flap_pending_q <= flap_pending_d;
      launch_q       <= launch_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (flap_pulse) state_d = StPlay;
      StPlay:  if (pipe_hit || (update && hit_floor)) state_d = StCrash;
      StCrash: if (flap_pulse && (hold_q == '0)) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath next values
  always_comb begin
    bird_y_d       = bird_y_q;
    old_y_d        = old_y_q;
    vel_d          = vel_q;
    score_d        = score_q;
    hold_d         = hold_q;
    draw_req_d     = draw_req_q & ~draw_ack;
    overrun_d      = overrun_q | (frame_tick & draw_req_q);
    flap_pending_d = flap_pending_q | flap_pulse;
    launch_d       = launch_q;

    if (update) begin
      bird_y_d       = y_new;
      old_y_d        = bird_y_q;
      vel_d          = vel_new;
      draw_req_d     = 1'b1;
      // A flap arriving with this tick waits for the next frame.
      flap_pending_d = flap_pulse;
      launch_d       = 1'b0;
    end

    if ((state_q == StPlay) && pipe_passed && (score_q < ScoreTop)) begin
      score_d = score_q + 7'd1;
    end

    if ((state_q == StCrash) && frame_tick && !draw_req_q && (hold_q != '0)) begin
      hold_d = hold_q - 7'd1;
    end

    if (state_d != state_q) begin
      flap_pending_d = 1'b0;
      launch_d       = 1'b0;
      case (state_d)
        StPlay: begin
          score_d  = '0;
          vel_d    = FlapVel;
          launch_d = 1'b1;
        end
        StCrash: hold_d = CrashHold;
        StIdle: begin
          bird_y_d   = YStart;
          old_y_d    = bird_y_q;
          vel_d      = '0;
          draw_req_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Outputs
  always_comb begin
    game_state = state_q;
    bird_y     = bird_y_q;
    old_y      = old_y_q;
    draw_req   = draw_req_q;
    score      = score_q;
    overrun    = overrun_q;
  end

endmodule

// File: doc/bird_motion_controller.md
# bird_motion_controller

Sequences the bird for one game: holds the IDLE/PLAY/CRASH game state, integrates flap and gravity into bird height once per video frame, detects floor and pipe crashes, and keeps score. Sits between the flap edge controller (one-cycle flap pulses), the pipe/collision logic and the frame renderer. Each position update is handed to the renderer through a req/ack handshake.

## Interface
- Y_W, 7: bird_y width (rows 0..119 of 160x120 screen)
- Y_START, 60: bird row in IDLE and after restart
- Y_MAX, 112: floor row; reaching it crashes
- FLAP_VEL, -4: velocity loaded on flap (rows/frame, negative = up)
- VEL_MAX, 4: terminal downward velocity
- CRASH_HOLD, 60: frames flaps are ignored after a crash
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- flap_pulse  in  1  one-cycle flap request
- frame_tick  in  1  one-cycle pulse per frame
- pipe_hit  in  1  level; bird overlaps a pipe
- pipe_passed  in  1  one-cycle pulse; pipe cleared
- draw_ack  in  1  renderer accepted draw_req
- bird_y  out  Y_W  current bird row
- draw_req  out  1  old_y/bird_y pending redraw
- old_y  out  Y_W  row before the last update
- game_state  out  2  0 IDLE, 1 PLAY, 2 CRASH
- score  out  7  pipes passed, 0..99
- overrun  out  1  sticky; frame_tick arrived while draw_req high

## Operation
- Reset: state IDLE, bird_y = old_y = Y_START, velocity 0, score 0, draw_req 0, overrun 0, flap_pending 0, hold counter 0.
- flap_pulse sets flap_pending; cleared when consumed by a frame update or on any state change.
- IDLE: bird stationary. flap_pulse -> PLAY, score cleared, velocity = FLAP_VEL, flap_pending cleared.
- PLAY, on frame_tick with draw_req low:
  - vel = FLAP_VEL if flap_pending else min(vel+1, VEL_MAX); signed 5-bit.
  - y_next = bird_y + vel (signed, Y_W+2 bits).
  - y_next <= 0: bird_y = 0, vel = 0, no crash.
  - y_next >= Y_MAX: bird_y = Y_MAX, go CRASH.
  - Else bird_y = y_next.
  - old_y takes the previous bird_y. draw_req set.
- PLAY, pipe_hit high on any cycle: go CRASH; bird_y frozen. If a position update happens on the same cycle, it is still applied and drawn.
- pipe_passed in PLAY: score+1, saturating at 99. Ignored in IDLE/CRASH.
- CRASH: hold counter loads CRASH_HOLD and decrements once per frame_tick. flap_pulse while counter nonzero is ignored. flap_pulse when counter is 0 -> IDLE: bird_y = Y_START, vel 0, draw_req set with old_y = crash row. Score is kept until the next PLAY.
- Handshake: draw_req stays high until a cycle where draw_ack is high; it drops the next cycle. old_y/bird_y stay stable while draw_req is high. frame_tick while draw_req is high is dropped and sets overrun; only reset clears overrun.

## Timing
- frame_tick at cycle t -> bird_y, old_y, draw_req valid at t+1.
- flap_pulse at t is consumed by any frame_tick at t+1 or later. flap_pulse and frame_tick in the same cycle: the flap is not used until the next frame.
- IDLE->PLAY: game_state = 1 at t+1 after flap_pulse.
- Crash: game_state = 2 the cycle after floor contact or pipe_hit.
- pipe_passed and crash in the same cycle: score still increments.
- Reset mid-handshake: draw_req drops next cycle; the renderer must tolerate this.

## Structure
- A shared game package holds the state encodings (IDLE/PLAY/CRASH), screen dimensions and the Y_W default.
- One natural sub-module, bird_physics_step: combinational velocity/position/clamp computation, leaving the FSM, score and handshake in the top level.

## Test plan
- Reset, then one flap_pulse -> game_state 1; first frame_tick -> bird_y 56, old_y 60, draw_req 1 until draw_ack.
- PLAY with no flaps from y 60, acking every frame -> velocity -3,-2,...,4 then held at 4; bird_y reaches 112 -> game_state 2, bird_y 112.
- Repeated flaps near the top -> bird_y clamps to 0, velocity 0, game_state stays 1.
- pipe_hit during PLAY -> CRASH next cycle. Flap within 60 frames is ignored; flap after 60 ticks -> IDLE, bird_y 60, draw_req 1 with old_y = crash row.
- 105 pipe_passed pulses -> score 99. A new game clears score to 0.
- frame_tick with draw_ack withheld -> bird_y unchanged, overrun 1, persisting until reset.
